// File: rtl/pm_controller.sv
// pm_controller
//
// Peripheral side of the OR1200 power-management interface. Watches the
// CPU's PM outputs, stalls the CPU while it sleeps, runs the low-voltage
// request/acknowledge exchange with the regulator, wakes the CPU on an
// interrupt or wake request, holds the stall for a resume delay, and makes
// the divided CPU clock-enable requested by clksd.
//
// Optional feature macro: PM_WAKE_TIMER_EN
//   defined   -> a 16-bit sleep timer forces a wake after WAKE_TIMEOUT SLEEP
//                cycles with no wake event and pulses timer_wake.
//   undefined -> no timer; SLEEP ends only on a wake event; timer_wake = 0.
//
// Ports
//   clock, reset       sole clock; synchronous active-high reset
//   pm_clksd_i         requested clock divide (0 = no division)
//   pm_cpu_gate_i      CPU asks to sleep
//   pm_wakeup_i        PM wakeup request from the CPU side
//   pm_lvolt_i         CPU asks for low voltage while asleep
//   pm_*_gate_i        dc/ic/dmmu/immu/tt gates, reserved (not acted upon)
//   pm_cpustall_o      stall to the CPU
//   interrupts         raw PIC lines; IRQ_WAKE_MASK selects wake sources
//   ext_wake           external level wake request
//   vreg_ack           regulator reports low voltage reached/held
//   vreg_low_req       request regulator low-voltage mode (level)
//   cpu_clk_en         CPU-domain clock enable
//   sleeping           high while in SLEEP
//   timer_wake         1-cycle pulse when the sleep timer caused the wake

module pm_controller #(
    parameter logic [19:0] IRQ_WAKE_MASK = 20'hFFFFF,
    parameter int unsigned RESUME_CYCLES = 8,
    parameter int unsigned WAKE_TIMEOUT  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  pm_clksd_i,
    input  logic        pm_cpu_gate_i,
    input  logic        pm_wakeup_i,
    input  logic        pm_lvolt_i,
    input  logic        pm_dc_gate_i,
    input  logic        pm_ic_gate_i,
    input  logic        pm_dmmu_gate_i,
    input  logic        pm_immu_gate_i,
    input  logic        pm_tt_gate_i,
    output logic        pm_cpustall_o,
    input  logic [19:0] interrupts,
    input  logic        ext_wake,
    input  logic        vreg_ack,
    output logic        vreg_low_req,
    output logic        cpu_clk_en,
    output logic        sleeping,
    output logic        timer_wake
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2
    } state_e;

    localparam logic [7:0] RESUME_LOAD = 8'(RESUME_CYCLES);

    state_e     state_q, state_d;
    logic       cpustall_q, cpustall_d;
    logic       vregLowReq_q, vregLowReq_d;
    logic       cpuClkEn_q, cpuClkEn_d;
    logic       sleeping_q, sleeping_d;
    logic       timerWake_q, timerWake_d;
    logic [3:0] divCnt_q, divCnt_d;
    logic [3:0] clksdPrev_q;
    logic [7:0] resumeCnt_q, resumeCnt_d;
    logic       wakeEv;
    logic       unusedGates;

    assign wakeEv      = pm_wakeup_i | ext_wake | (|(interrupts & IRQ_WAKE_MASK));
    assign unusedGates = ^{pm_dc_gate_i, pm_ic_gate_i, pm_dmmu_gate_i, pm_immu_gate_i, pm_tt_gate_i};

`ifdef PM_WAKE_TIMER_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(WAKE_TIMEOUT - 1);

    logic [15:0] sleepTimer_q, sleepTimer_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sleepTimer_q <= 16'd0;
        end else begin
            sleepTimer_q <= sleepTimer_d;
        end
    end
`else
    localparam int unsigned unusedTimeout = WAKE_TIMEOUT;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RUN;
            cpustall_q   <= 1'b0;
            vregLowReq_q <= 1'b0;
            cpuClkEn_q   <= 1'b1;
            sleeping_q   <= 1'b0;
            timerWake_q  <= 1'b0;
            divCnt_q     <= 4'd0;
            clksdPrev_q  <= 4'd0;
            resumeCnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cpustall_q   <= cpustall_d;
            vregLowReq_q <= vregLowReq_d;
            cpuClkEn_q   <= cpuClkEn_d;
            sleeping_q   <= sleeping_d;
            timerWake_q  <= timerWake_d;
            divCnt_q     <= divCnt_d;
            clksdPrev_q  <= pm_clksd_i;
            resumeCnt_q  <= resumeCnt_d;
        end
    end

    // resumeCnt_q == 0 in WAKE means the regulator has not yet released
    // low voltage; the count only starts once vreg_ack is seen low, and the
    // state returns to RUN on the edge that would take the count to zero.
    always_comb begin
        state_d      = state_q;
        vregLowReq_d = vregLowReq_q;
        divCnt_d     = divCnt_q;
        resumeCnt_d  = resumeCnt_q;
        timerWake_d  = 1'b0;
`ifdef PM_WAKE_TIMER_EN
        sleepTimer_d = sleepTimer_q;
`endif
        case (state_q)
            RUN: begin
                if (pm_cpu_gate_i && !wakeEv) begin
                    state_d      = SLEEP;
                    vregLowReq_d = pm_lvolt_i;
                    divCnt_d     = 4'd0;
`ifdef PM_WAKE_TIMER_EN
                    sleepTimer_d = 16'd0;
`endif
                end else if (pm_clksd_i != clksdPrev_q) begin
                    divCnt_d = 4'd0;
                end else if (divCnt_q >= pm_clksd_i) begin
                    divCnt_d = 4'd0;
                end else begin
                    divCnt_d = divCnt_q + 4'd1;
                end
            end
            SLEEP: begin
                if (wakeEv) begin
                    state_d      = WAKE;
                    vregLowReq_d = 1'b0;
                    resumeCnt_d  = vreg_ack ? 8'd0 : RESUME_LOAD;
`ifdef PM_WAKE_TIMER_EN
                end else if (sleepTimer_q == TIMEOUT_LAST) begin
                    state_d      = WAKE;
                    vregLowReq_d = 1'b0;
                    resumeCnt_d  = vreg_ack ? 8'd0 : RESUME_LOAD;
                    timerWake_d  = 1'b1;
                end else begin
                    sleepTimer_d = sleepTimer_q + 16'd1;
`endif
                end
            end
            WAKE: begin
                if (resumeCnt_q == 8'd0) begin
                    if (!vreg_ack) begin
                        resumeCnt_d = RESUME_LOAD;
                    end
                end else if (resumeCnt_q == 8'd1) begin
                    state_d     = RUN;
                    resumeCnt_d = 8'd0;
                    divCnt_d    = 4'd0;
                end else begin
                    resumeCnt_d = resumeCnt_q - 8'd1;
                end
            end
            default: begin
                state_d      = RUN;
                vregLowReq_d = 1'b0;
                divCnt_d     = 4'd0;
                resumeCnt_d  = 8'd0;
            end
        endcase

        cpustall_d = (state_d != RUN);
        sleeping_d = (state_d == SLEEP);
        cpuClkEn_d = (state_d == RUN) && (divCnt_d == 4'd0);
    end

    assign pm_cpustall_o = cpustall_q;
    assign vreg_low_req  = vregLowReq_q;
    assign cpu_clk_en    = cpuClkEn_q;
    assign sleeping      = sleeping_q;
    assign timer_wake    = timerWake_q;

endmodule

// File: tb/tb_pm_controller.sv
// tb_pm_controller
//
// Self-checking bench for pm_controller. A table of hand-computed vectors
// covers the directed scenarios (divider patterns, sleep/wake with the
// regulator handshake, masked interrupts, reset during WAKE/SLEEP), then a
// long randomized run is compared cycle by cycle against a behavioural
// model built on edge numbers and modular arithmetic.

module tb_pm_controller;

    localparam logic [19:0] MASK = 20'hFFF25;
    localparam int          RES  = 8;
    localparam int          TMO  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  pm_clksd;
    logic        pm_cpu_gate, pm_wakeup, pm_lvolt;
    logic        pm_cpustall;
    logic [19:0] interrupts;
    logic        ext_wake, vreg_ack;
    logic        vreg_low_req, cpu_clk_en, sleeping, timer_wake;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pm_controller #(
        .IRQ_WAKE_MASK (MASK),
        .RESUME_CYCLES (RES),
        .WAKE_TIMEOUT  (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pm_clksd_i     (pm_clksd),
        .pm_cpu_gate_i  (pm_cpu_gate),
        .pm_wakeup_i    (pm_wakeup),
        .pm_lvolt_i     (pm_lvolt),
        .pm_dc_gate_i   (1'b0),
        .pm_ic_gate_i   (1'b0),
        .pm_dmmu_gate_i (1'b0),
        .pm_immu_gate_i (1'b0),
        .pm_tt_gate_i   (1'b0),
        .pm_cpustall_o  (pm_cpustall),
        .interrupts     (interrupts),
        .ext_wake       (ext_wake),
        .vreg_ack       (vreg_ack),
        .vreg_low_req   (vreg_low_req),
        .cpu_clk_en     (cpu_clk_en),
        .sleeping       (sleeping),
        .timer_wake     (timer_wake)
    );

    typedef struct {
        logic        rst, gate, lvolt, wk, ext;
        logic [19:0] irq;
        logic        ack;
        logic [3:0]  clksd;
        logic        eStall, eVlow, eEn, eSlp;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: modes plus edge-number bookkeeping.
    int         edgeNo      = 0;
    int         restartEdge = 0;
    int         resumeAt    = -1;
    int         sleepStart  = 0;
    bit         mAsleep     = 1'b0;
    bit         mWaking     = 1'b0;
    bit         mVlow       = 1'b0;
    bit         mTw         = 1'b0;
    logic [3:0] mPrev       = 4'd0;

    function automatic vec_t mk(input logic rst, gate, lvolt, wk, ext,
                                input logic [19:0] irq, input logic ack,
                                input logic [3:0] clksd,
                                input logic eStall, eVlow, eEn, eSlp);
        vec_t v;
        v.rst = rst; v.gate = gate; v.lvolt = lvolt; v.wk = wk; v.ext = ext;
        v.irq = irq; v.ack = ack; v.clksd = clksd;
        v.eStall = eStall; v.eVlow = eVlow; v.eEn = eEn; v.eSlp = eSlp;
        return v;
    endfunction

    task automatic modelStep();
        bit wakeEv;
        edgeNo++;
        wakeEv = pm_wakeup | ext_wake | (|(interrupts & MASK));
        mTw = 1'b0;
        if (reset) begin
            mAsleep = 1'b0; mWaking = 1'b0; mVlow = 1'b0;
            restartEdge = edgeNo; resumeAt = -1; mPrev = 4'd0;
        end else begin
            if (mWaking) begin
                if (resumeAt < 0) begin
                    if (!vreg_ack) resumeAt = edgeNo + RES;
                end else if (edgeNo == resumeAt) begin
                    mWaking = 1'b0; restartEdge = edgeNo; resumeAt = -1;
                end
            end else if (mAsleep) begin
                if (wakeEv) begin
                    mAsleep = 1'b0; mWaking = 1'b0 | 1'b1; mVlow = 1'b0;
                    resumeAt = vreg_ack ? -1 : edgeNo + RES;
`ifdef PM_WAKE_TIMER_EN
                end else if (edgeNo - sleepStart == TMO) begin
                    mAsleep = 1'b0; mWaking = 1'b1; mVlow = 1'b0; mTw = 1'b1;
                    resumeAt = vreg_ack ? -1 : edgeNo + RES;
`endif
                end
            end else begin
                if (pm_cpu_gate && !wakeEv) begin
                    mAsleep = 1'b1; mVlow = pm_lvolt; sleepStart = edgeNo;
                end else if (pm_clksd != mPrev) begin
                    restartEdge = edgeNo;
                end
            end
            mPrev = pm_clksd;
        end
    endtask

    function automatic logic [4:0] modelOut();
        bit running;
        bit en;
        running = !mAsleep && !mWaking;
        en = running && (((edgeNo - restartEdge) % (int'(mPrev) + 1)) == 0);
        return {mAsleep | mWaking, mVlow, en, mAsleep, mTw};
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        reset = v.rst; pm_cpu_gate = v.gate; pm_lvolt = v.lvolt;
        pm_wakeup = v.wk; ext_wake = v.ext; interrupts = v.irq;
        vreg_ack = v.ack; pm_clksd = v.clksd;
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {pm_cpustall, vreg_low_req, cpu_clk_en, sleeping, timer_wake};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: stall/vlow/clken/sleeping/twake got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        bit   ackR;
        logic [3:0] clksdR;

        reset = 1'b1; pm_cpu_gate = 1'b0; pm_lvolt = 1'b0; pm_wakeup = 1'b0;
        ext_wake = 1'b0; interrupts = 20'h0; vreg_ack = 1'b0; pm_clksd = 4'd0;

        // Reset values, then divider clksd=0 -> 3.
        tbl.push_back(mk(1,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        // cpu_gate with a masked-in interrupt the same cycle: stay in RUN.
        tbl.push_back(mk(0,1,0,0,0,20'h00004,0,4'd3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,1,0));
        // Sleep with low voltage, regulator acks, irq7 masked out, irq5 wakes.
        tbl.push_back(mk(0,1,1,0,0,20'h0,0,4'd3, 1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,20'h0,1,4'd3, 1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,20'h00080,1,4'd3, 1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,20'h00020,1,4'd3, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,1,4'd3, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,1,4'd3, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 1,0,0,0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0,(i == 1),0,0,0,20'h0,0,4'd3, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,0,0));
        // Sleep without low voltage; irq7 ignored; ext_wake with ack low.
        tbl.push_back(mk(0,1,0,0,0,20'h0,0,4'd3, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,20'h00080,0,4'd3, 1,0,0,1));
        tbl.push_back(mk(0,0,0,0,1,20'h0,0,4'd3, 1,0,0,0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd3, 0,0,1,0));
        // Reset while WAKE count is 4, then reset while asleep with vreg_low_req up.
        tbl.push_back(mk(0,1,1,0,0,20'h0,0,4'd0, 1,1,0,1));
        tbl.push_back(mk(0,0,0,1,0,20'h0,0,4'd0, 1,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,20'h0,0,4'd0, 1,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd0, 0,0,1,0));
        // Divider clksd=1, then the clksd=15 extreme.
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd1, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd1, 0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd15, 0,0,1,0));
        for (int i = 0; i < 15; i++)
            tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd15, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,20'h0,0,4'd15, 0,0,1,0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i),
                        {tbl[i].eStall, tbl[i].eVlow, tbl[i].eEn, tbl[i].eSlp, 1'b0});
        end

        // Randomized run against the model.
        ackR   = 1'b0;
        clksdR = 4'd0;
        v = mk(1,0,0,0,0,20'h0,0,4'd0, 0,0,1,0);
        applyStimulus(v);
        checkOutput("rand_reset", modelOut());
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) ackR = ~ackR;
            if ($urandom_range(0, 39) == 0) clksdR = 4'($urandom_range(0, 15));
            v.rst   = ($urandom_range(0, 399) == 0);
            v.gate  = ($urandom_range(0, 5) == 0);
            v.lvolt = 1'($urandom_range(0, 1));
            v.wk    = ($urandom_range(0, 29) == 0);
            v.ext   = ($urandom_range(0, 39) == 0);
            v.irq   = ($urandom_range(0, 9) == 0) ? (20'h1 << $urandom_range(0, 19)) : 20'h0;
            v.ack   = ackR;
            v.clksd = clksdR;
            applyStimulus(v);
            checkOutput($sformatf("rand%0d", n), modelOut());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
